result_checker: RTL and testbench

Hardware self-check unit at the data-memory side of the core. It snoops the DM write port for the program's halt store (byte 0xff to 0xfffc). It then reads the answer region word by word through a DM read port and compares each word against a golden ROM, reporting pass/fail, error count and first mismatch. This lets regression and FPGA runs check results without simulator-only memory peeking, and it enforces a cycle-limit timeout.

---
 rtl/result_checker.sv | 157 +++++++++++++++
 tb/tb_result_checker.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_checker.sv
// result_checker: hardware self-check at the data-memory side of the core.
// Waits for the program's halt store, then reads the answer region one word
// at a time through a DM read port and compares each word with a golden ROM.
// It reports pass/fail, a saturating error count and the first mismatch, and
// declares a timeout if the halt store never arrives.
module result_checker #(
   parameter int unsigned       ADDR_W       = 16,
   parameter logic [ADDR_W-1:0] ANSWER_START = 16'h9000,
   parameter logic [ADDR_W-1:0] HALT_ADDR    = 16'hfffc,
   parameter logic [7:0]        HALT_VAL     = 8'hff,
   parameter int unsigned       MAX_WORDS    = 100,
   parameter int unsigned       TIMEOUT      = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_waddr,
   input  logic [3:0]        dm_wstrb,
   input  logic [31:0]       dm_wdata,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_valid,
   input  logic [31:0]       rd_data,
   input  logic [6:0]        gold_num,
   output logic [6:0]        gold_idx,
   input  logic [31:0]       gold_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [7:0]        err_cnt,
   output logic [6:0]        first_err_idx,
   output logic [31:0]       first_err_data
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_CMP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_TOUT = 3'd5;

   localparam int unsigned      CYC_W    = $clog2(TIMEOUT + 1);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
   localparam logic [6:0]       MAX_N    = 7'(MAX_WORDS);

   logic [2:0]        r_state;
   logic [CYC_W-1:0]  r_cyc;
   logic [6:0]        r_idx;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [31:0]       r_rd_data;
   logic [7:0]        r_err_cnt;
   logic [6:0]        r_first_idx;
   logic [31:0]       r_first_data;

   logic       w_halt;
   logic [6:0] w_n;
   logic       w_last;
   logic       w_mismatch;
   logic       w_unused;

   // Error counter stops at 255 instead of wrapping back to a passing value.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

   // Byte address of answer word idx, wrapping modulo the address space.
   function automatic logic [ADDR_W-1:0] addr_of(input logic [6:0] idx);
      return ANSWER_START + ADDR_W'({idx, 2'b00});
   endfunction

   // Only lane 0 of the mailbox carries the halt code; other lanes are don't-care.
   assign w_halt     = dm_we && dm_wstrb[0] && (dm_waddr == HALT_ADDR) &&
                       (dm_wdata[7:0] == HALT_VAL);
   assign w_n        = (gold_num > MAX_N) ? MAX_N : gold_num;
   assign w_last     = (r_idx == (w_n - 7'd1));
   assign w_mismatch = (r_rd_data != gold_data);
   assign w_unused   = ^{dm_wstrb[3:1], dm_wdata[31:8]};

   // Sequencer: halt detection and timeout in IDLE, then one REQ/WAIT/CMP pass per word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cyc        <= '0;
         r_idx        <= '0;
         r_rd_addr    <= '0;
         r_err_cnt    <= '0;
         r_first_idx  <= '0;
         r_first_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // A halt in the same cycle as the last timeout tick still counts.
               if (w_halt) begin
                  r_idx <= '0;
                  if (w_n == 7'd0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state   <= S_REQ;
                     r_rd_addr <= addr_of(7'd0);
                  end
               end else if (r_cyc == CYC_LAST) begin
                  r_state <= S_TOUT;
               end else begin
                  r_cyc <= r_cyc + CYC_W'(1);
               end
            end
            S_REQ: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (rd_valid) begin
                  r_state <= S_CMP;
               end
            end
            S_CMP: begin
               if (w_mismatch) begin
                  r_err_cnt <= sat_inc8(r_err_cnt);
                  if (r_err_cnt == 8'd0) begin
                     r_first_idx  <= r_idx;
                     r_first_data <= r_rd_data;
                  end
               end
               if (w_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx     <= r_idx + 7'd1;
                  r_rd_addr <= addr_of(r_idx + 7'd1);
                  r_state   <= S_REQ;
               end
            end
            default: begin
               // DONE and TOUT hold until reset.
            end
         endcase
      end
   end

   // Read-data capture; rd_valid is only honoured while a read is outstanding.
   always_ff @(posedge clk) begin
      if (r_state == S_WAIT && rd_valid) begin
         r_rd_data <= rd_data;
      end
   end

   assign rd_req         = (r_state == S_REQ);
   assign rd_addr        = r_rd_addr;
   assign gold_idx       = r_idx;
   assign busy           = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_CMP);
   assign done           = (r_state == S_DONE) || (r_state == S_TOUT);
   assign pass           = (r_state == S_DONE) && (r_err_cnt == 8'd0);
   assign timeout        = (r_state == S_TOUT);
   assign err_cnt        = r_err_cnt;
   assign first_err_idx  = r_first_idx;
   assign first_err_data = r_first_data;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: a timestamp-based model of the check sequence,
// a DM read responder with configurable latency, and directed scenarios.
module tb_result_checker;

   localparam int TOUT = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        dm_we = 1'b0;
   logic [15:0] dm_waddr = '0;
   logic [3:0]  dm_wstrb = '0;
   logic [31:0] dm_wdata = '0;
   logic        rd_req;
   logic [15:0] rd_addr;
   logic        rd_valid = 1'b0;
   logic [31:0] rd_data = '0;
   logic [6:0]  gold_num = '0;
   logic [6:0]  gold_idx;
   logic [31:0] gold_data;
   logic        busy, done, pass, timeout;
   logic [7:0]  err_cnt;
   logic [6:0]  first_err_idx;
   logic [31:0] first_err_data;

   logic [31:0] gold [128];
   logic [31:0] mem  [128];
   int          val_cyc [128];   // cycle in which word j's rd_valid was presented
   logic [15:0] req_log [$];

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   int rel_cyc = 0;
   int halt_cyc = -1;
   int gen = 0;
   int lat_mode = 1;             // 0: random 1..5, else fixed latency
   bit chk_en = 1'b0;
   int r_cnt = 0;
   int r_gen = 0;
   int r_w = 0;

   assign gold_data = gold[gold_idx];

   result_checker #(
      .ADDR_W(16), .ANSWER_START(16'h9000), .HALT_ADDR(16'hfffc),
      .HALT_VAL(8'hff), .MAX_WORDS(100), .TIMEOUT(TOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .gold_num(gold_num), .gold_idx(gold_idx), .gold_data(gold_data),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .err_cnt(err_cnt), .first_err_idx(first_err_idx), .first_err_data(first_err_data)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, ncyc - rel_cyc, act, exp);
      end
   endtask

   // DM read responder: rd_valid arrives lat cycles after the request cycle.
   initial begin
      forever begin
         @(posedge clk); #1;
         rd_valid = 1'b0;
         if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) begin
               rd_valid = 1'b1;
               rd_data  = mem[r_w];
               if (r_gen == gen) val_cyc[r_w] = ncyc;
            end
         end
         if (rd_req === 1'b1) begin
            r_w   = int'((rd_addr - 16'h9000) >> 2) & 127;
            r_gen = gen;
            req_log.push_back(rd_addr);
            r_cnt = (lat_mode == 0) ? int'($urandom_range(5, 1)) : lat_mode;
         end
      end
   end

   // Expected outputs for the current cycle, derived from the halt time and
   // the cycles at which each word's read data was delivered.
   task automatic compare_cycle();
      int k, n, comp, errs, fidx, rq, exp_gidx;
      logic [31:0] fdata;
      bit hv, tout, fin, run, exp_req;
      k = ncyc;
      n = (int'(gold_num) > 100) ? 100 : int'(gold_num);
      hv = (halt_cyc >= 0);
      comp = 0; errs = 0; fidx = 0; fdata = '0;
      if (hv) begin
         for (int j = 0; j < n; j++) begin
            if (val_cyc[j] >= 0 && val_cyc[j] + 2 <= k) begin
               comp++;
               if (mem[j] !== gold[j]) begin
                  if (errs == 0) begin fidx = j; fdata = mem[j]; end
                  errs++;
               end
            end
         end
      end
      tout = !hv && (k >= rel_cyc + TOUT);
      fin  = hv && (k > halt_cyc) && (comp == n);
      run  = hv && (k > halt_cyc) && (comp < n);
      exp_req = 1'b0;
      exp_gidx = 0;
      if (run) begin
         rq = (comp == 0) ? halt_cyc + 1 : val_cyc[comp - 1] + 2;
         exp_req = (k == rq);
         exp_gidx = comp;
         if (k >= rq && (val_cyc[comp] < 0 || k <= val_cyc[comp]))
            chk("rd_addr", 32'(rd_addr), 32'h9000 + 32'(4 * comp));
      end else if (fin && n > 0) begin
         exp_gidx = n - 1;
      end
      if (!hv) chk("rd_addr_idle", 32'(rd_addr), 32'h0);
      chk("rd_req", 32'(rd_req), 32'(exp_req));
      chk("busy", 32'(busy), 32'(run));
      chk("done", 32'(done), 32'(fin || tout));
      chk("pass", 32'(pass), 32'(fin && errs == 0));
      chk("timeout", 32'(timeout), 32'(tout));
      chk("err_cnt", 32'(err_cnt), 32'((errs > 255) ? 255 : errs));
      chk("first_err_idx", 32'(first_err_idx), 32'(fidx));
      chk("first_err_data", first_err_data, fdata);
      chk("gold_idx", 32'(gold_idx), 32'(exp_gidx));
   endtask

   always @(negedge clk) if (chk_en) compare_cycle();

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_cycle(input int c);
      while (ncyc < c) step();
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst = 1'b0;
      gen++;
      halt_cyc = -1;
      foreach (val_cyc[j]) val_cyc[j] = -1;
      req_log.delete();
      step();
      step();
      rst = 1'b1;
      rel_cyc = ncyc;
      chk_en = 1'b1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
      dm_we = 1'b1; dm_waddr = a; dm_wstrb = s; dm_wdata = d;
      if (s[0] && a == 16'hfffc && d[7:0] == 8'hff && halt_cyc < 0 && ncyc < rel_cyc + TOUT)
         halt_cyc = ncyc;
      step();
      dm_we = 1'b0; dm_waddr = '0; dm_wstrb = '0; dm_wdata = '0;
   endtask

   task automatic halt();
      bus_write(16'hfffc, 4'b0001, 32'ha5a5a5ff);
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      int b;
      b = 0;
      while (done !== 1'b1 && b < budget) begin step(); b++; end
      dcyc = ncyc;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_wait: done still 0 after %0d cycles, expected 1", budget);
      end
   endtask

   task automatic load_match(input int n);
      for (int j = 0; j < 128; j++) begin
         gold[j] = 32'h1111_1111 * 32'(j + 1);
         mem[j]  = (j < n) ? gold[j] : 32'h0;
      end
   endtask

   initial begin
      int d;
      #1;

      // Four matching words, latency 1
      load_match(4);
      gold_num = 7'd4;
      lat_mode = 1;
      do_reset();
      chk("reset_done", 32'(done), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rd_addr", 32'(rd_addr), 0);
      chk("reset_err_cnt", 32'(err_cnt), 0);
      wait_cycle(rel_cyc + 20);
      halt();
      wait_done(60, d);
      chk("t1_done_cycle", 32'(d - rel_cyc), 33);
      chk("t1_pass", 32'(pass), 1);
      chk("t1_err_cnt", 32'(err_cnt), 0);
      chk("t1_req_count", 32'(req_log.size()), 4);
      if (req_log.size() == 4) begin
         chk("t1_addr0", 32'(req_log[0]), 32'h9000);
         chk("t1_addr1", 32'(req_log[1]), 32'h9004);
         chk("t1_addr2", 32'(req_log[2]), 32'h9008);
         chk("t1_addr3", 32'(req_log[3]), 32'h900c);
      end

      // One mismatching word
      gold[2] = 32'h12345678;
      mem[2]  = 32'hdeadbeef;
      do_reset();
      wait_cycle(rel_cyc + 20);
      halt();
      wait_done(60, d);
      chk("t2_done_cycle", 32'(d - rel_cyc), 33);
      chk("t2_pass", 32'(pass), 0);
      chk("t2_err_cnt", 32'(err_cnt), 1);
      chk("t2_first_idx", 32'(first_err_idx), 2);
      chk("t2_first_data", first_err_data, 32'hdeadbeef);

      // 100 words (gold_num clamped from 127), all mismatching, random latency
      for (int j = 0; j < 128; j++) begin
         gold[j] = 32'(j * 3);
         mem[j]  = ~gold[j];
      end
      gold_num = 7'd127;
      lat_mode = 0;
      do_reset();
      wait_cycle(rel_cyc + 10);
      halt();
      wait_done(1000, d);
      chk("t3_err_cnt", 32'(err_cnt), 100);
      chk("t3_pass", 32'(pass), 0);
      chk("t3_first_idx", 32'(first_err_idx), 0);
      chk("t3_first_data", first_err_data, 32'hffffffff);
      chk("t3_req_count", 32'(req_log.size()), 100);

      // Writes that must not trigger, then a real halt plus a redundant one
      load_match(4);
      gold_num = 7'd4;
      lat_mode = 2;
      do_reset();
      wait_cycle(rel_cyc + 5);
      bus_write(16'hfffc, 4'b0001, 32'h000000fe);
      bus_write(16'hfffc, 4'b0010, 32'h0000ffff);
      bus_write(16'hfff8, 4'b0001, 32'h000000ff);
      repeat (5) step();
      chk("t4_no_trigger_busy", 32'(busy), 0);
      chk("t4_no_trigger_req", 32'(req_log.size()), 0);
      wait_cycle(rel_cyc + 30);
      halt();
      halt();
      wait_done(60, d);
      chk("t4_done_cycle", 32'(d - rel_cyc), 30 + 4 * 4 + 1);
      chk("t4_pass", 32'(pass), 1);

      // Zero golden words: done with pass on the cycle after the halt
      gold_num = 7'd0;
      do_reset();
      wait_cycle(rel_cyc + 7);
      halt();
      chk("t5_done", 32'(done), 1);
      chk("t5_pass", 32'(pass), 1);
      chk("t5_req_count", 32'(req_log.size()), 0);

      // No halt: timeout at cycle TOUT; a later halt is ignored
      gold_num = 7'd4;
      lat_mode = 1;
      do_reset();
      wait_cycle(rel_cyc + TOUT - 1);
      chk("t6_timeout_early", 32'(timeout), 0);
      step();
      chk("t6_timeout", 32'(timeout), 1);
      chk("t6_done", 32'(done), 1);
      chk("t6_pass", 32'(pass), 0);
      halt();
      repeat (8) step();
      chk("t6_no_req_after", 32'(req_log.size()), 0);
      chk("t6_busy_after", 32'(busy), 0);

      // Reset during WAIT of word 5 with a late rd_valid, then a clean re-run
      load_match(8);
      gold_num = 7'd8;
      lat_mode = 5;
      do_reset();
      wait_cycle(rel_cyc + 10);
      halt();
      begin
         int b;
         b = 0;
         while (req_log.size() < 6 && b < 200) begin @(posedge clk); #2; b++; end
      end
      chk("t7_reached_word5", 32'(req_log.size()), 6);
      step();
      chk("t7_in_wait_busy", 32'(busy), 1);
      chk("t7_in_wait_req", 32'(rd_req), 0);
      do_reset();
      chk("t7_after_reset_busy", 32'(busy), 0);
      chk("t7_after_reset_gidx", 32'(gold_idx), 0);
      repeat (4) step();
      chk("t7_stale_ignored", 32'(busy), 0);
      wait_cycle(rel_cyc + 10);
      halt();
      wait_done(100, d);
      chk("t7_done_cycle", 32'(d - rel_cyc), 10 + 8 * 7 + 1);
      chk("t7_pass", 32'(pass), 1);
      chk("t7_err_cnt", 32'(err_cnt), 0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
